// File: rtl/uart_apb_stream_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_apb_stream_bridge_pkg: UART register map, status bits, FSM encodings  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package uart_apb_stream_bridge_pkg;

  localparam logic [4:0] c_ADDR_TXDATA = 5'h00;
  localparam logic [4:0] c_ADDR_RXDATA = 5'h04;
  localparam logic [4:0] c_ADDR_CTRL1  = 5'h08;
  localparam logic [4:0] c_ADDR_CTRL2  = 5'h0C;
  localparam logic [4:0] c_ADDR_STATUS = 5'h10;

  localparam int c_ST_TXRDY  = 0;
  localparam int c_ST_RXRDY  = 1;
  localparam int c_ST_PARERR = 2;
  localparam int c_ST_FRERR  = 4;

  typedef enum logic [2:0] {
    ST_CFG1  = 3'd0,
    ST_CFG2  = 3'd1,
    ST_POLL  = 3'd2,
    ST_RD_RX = 3'd3,
    ST_WR_TX = 3'd4
  } bridge_state_t;

  typedef enum logic [1:0] {
    XF_IDLE   = 2'd0,
    XF_SETUP  = 2'd1,
    XF_ACCESS = 2'd2
  } xfer_state_t;

  // CTRL2 = {baud[12:8], odd, parity enable, 8-bit}
  function automatic logic [7:0] ctrl2_word(input logic [12:0] baud,
                                            input logic        bit8,
                                            input logic [1:0]  parity);
    return {baud[12:8], (parity == 2'd2), (parity != 2'd0), bit8};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_apb_stream_bridge_apb_master_xfer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb_master_xfer: single APB transfer engine (IDLE -> SETUP -> ACCESS)      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module apb_master_xfer
  import uart_apb_stream_bridge_pkg::*;
(
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic       i_start,
  input  logic       i_write,
  input  logic [4:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic       o_idle,
  output logic       o_done,
  output logic [7:0] o_rdata,
  output logic       o_err,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [4:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR
);

  xfer_state_t r_state;
  xfer_state_t w_next;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) r_state <= XF_IDLE;
    else          r_state <= w_next;
  end

  // Completion always returns to IDLE, so PSEL drops for at least one cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      XF_IDLE:   if (i_start) w_next = XF_SETUP;
      XF_SETUP:  w_next = XF_ACCESS;
      XF_ACCESS: if (PREADY) w_next = XF_IDLE;
      default:   w_next = XF_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      PWRITE <= 1'b0;
      PADDR  <= 5'h00;
      PWDATA <= 8'h00;
    end else if (r_state == XF_IDLE && i_start) begin
      PWRITE <= i_write;
      PADDR  <= i_addr;
      PWDATA <= i_wdata;
    end
  end

  assign PSEL    = (r_state != XF_IDLE);
  assign PENABLE = (r_state == XF_ACCESS);
  assign o_idle  = (r_state == XF_IDLE);
  assign o_done  = (r_state == XF_ACCESS) && PREADY;
  assign o_rdata = PRDATA;
  assign o_err   = PSLVERR;

endmodule
`default_nettype wire

// File: rtl/uart_apb_stream_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_apb_stream_bridge: byte streams <-> CoreUARTapb register APB master   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_apb_stream_bridge
  import uart_apb_stream_bridge_pkg::*;
#(
  parameter logic [12:0] BAUD_VALUE = 13'd1,
  parameter bit          PRG_BIT8   = 1'b1,
  parameter logic [1:0]  PRG_PARITY = 2'd0,
  parameter bit          CFG_INIT   = 1'b1
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [4:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic       PSLVERR,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [2:0] rx_err,
  output logic       init_done,
  output logic       apb_err
);

  localparam logic [7:0] c_CTRL2 = ctrl2_word(BAUD_VALUE, PRG_BIT8, PRG_PARITY);

  bridge_state_t r_state;
  bridge_state_t w_next;
  logic          w_start, w_write, w_idle, w_done, w_err;
  logic [4:0]    w_addr;
  logic [7:0]    w_wdata, w_rdata;
  logic [7:0]    r_tx_hold;
  logic          r_tx_full;
  logic [2:0]    r_stat_err;

  apb_master_xfer u_xfer (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .i_start (w_start),
    .i_write (w_write),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_idle  (w_idle),
    .o_done  (w_done),
    .o_rdata (w_rdata),
    .o_err   (w_err),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) r_state <= ST_CFG1;
    else          r_state <= w_next;
  end

  // Each state launches one transfer whenever the engine is idle; done moves on
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_write = 1'b0;
    w_addr  = c_ADDR_STATUS;
    w_wdata = 8'h00;
    case (r_state)
      ST_CFG1: begin
        w_write = 1'b1;
        w_addr  = c_ADDR_CTRL1;
        w_wdata = BAUD_VALUE[7:0];
        if (!CFG_INIT) begin
          w_next = ST_POLL;
        end else begin
          w_start = w_idle;
          if (w_done) w_next = ST_CFG2;
        end
      end
      ST_CFG2: begin
        w_write = 1'b1;
        w_addr  = c_ADDR_CTRL2;
        w_wdata = c_CTRL2;
        w_start = w_idle;
        if (w_done) w_next = ST_POLL;
      end
      ST_POLL: begin
        w_start = w_idle;
        if (w_done) begin
          if (w_rdata[c_ST_RXRDY] && !rx_valid)     w_next = ST_RD_RX;
          else if (w_rdata[c_ST_TXRDY] && r_tx_full) w_next = ST_WR_TX;
          else                                       w_next = ST_POLL;
        end
      end
      ST_RD_RX: begin
        w_addr  = c_ADDR_RXDATA;
        w_start = w_idle;
        if (w_done) w_next = ST_POLL;
      end
      ST_WR_TX: begin
        w_write = 1'b1;
        w_addr  = c_ADDR_TXDATA;
        w_wdata = r_tx_hold;
        w_start = w_idle;
        if (w_done) w_next = ST_POLL;
      end
      default: w_next = ST_CFG1;
    endcase
  end

  assign tx_ready = init_done && !r_tx_full;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      init_done  <= 1'b0;
      apb_err    <= 1'b0;
      r_tx_hold  <= 8'h00;
      r_tx_full  <= 1'b0;
      r_stat_err <= 3'b000;
      rx_data    <= 8'h00;
      rx_err     <= 3'b000;
      rx_valid   <= 1'b0;
    end else begin
      if ((r_state == ST_CFG2 && w_done) || (!CFG_INIT && r_state == ST_CFG1))
        init_done <= 1'b1;
      if (w_done && w_err)
        apb_err <= 1'b1;
      if (r_state == ST_WR_TX && w_done) begin
        r_tx_full <= 1'b0;
      end else if (tx_valid && tx_ready) begin
        r_tx_hold <= tx_data;
        r_tx_full <= 1'b1;
      end
      // Error bits only reach rx_err through a read that follows this poll
      if (r_state == ST_POLL && w_done)
        r_stat_err <= w_rdata[c_ST_FRERR:c_ST_PARERR];
      if (r_state == ST_RD_RX && w_done) begin
        rx_data  <= w_rdata;
        rx_err   <= r_stat_err;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_apb_stream_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_apb_stream_bridge: directed bench with a behavioural UART slave    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_uart_apb_stream_bridge;

  logic       PCLK = 1'b0;
  logic       PRESETN;
  logic       PSEL, PENABLE, PWRITE;
  logic [4:0] PADDR;
  logic [7:0] PWDATA, PRDATA;
  logic       PREADY, PSLVERR;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [2:0] rx_err;
  logic       init_done, apb_err;

  // Divisor 0x545 gives CTRL1 = 0x45 and CTRL2 = {5'h05,0,0,1} = 0x29
  uart_apb_stream_bridge #(
    .BAUD_VALUE (13'h545),
    .PRG_BIT8   (1'b1),
    .PRG_PARITY (2'd0),
    .CFG_INIT   (1'b1)
  ) dut (
    .PCLK      (PCLK),
    .PRESETN   (PRESETN),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_err    (rx_err),
    .init_done (init_done),
    .apb_err   (apb_err)
  );

  always #5 PCLK = ~PCLK;

  // Behavioural UART register slave
  int         wait_n = 0;
  int         acc_cnt = 0;
  logic [7:0] rxmem [16];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  logic [2:0] st_err = 3'b000;
  int         slverr_req = 0;
  int         slverr_done = 0;
  logic [4:0] wl_addr [64];
  logic [7:0] wl_data [64];
  int         wl_n = 0;
  int         rd_cnt = 0;

  assign PREADY  = (acc_cnt >= wait_n);
  assign PSLVERR = (slverr_req != slverr_done) && PSEL && PENABLE && PREADY;
  assign PRDATA  = (PADDR == 5'h10) ? {3'b000, st_err, (wr_ptr != rd_ptr), 1'b1}
                                    : rxmem[rd_ptr[3:0]];

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (PSEL && PENABLE && PREADY) begin
      if (PWRITE) begin
        if (wl_n < 64) begin
          wl_addr[wl_n] <= PADDR;
          wl_data[wl_n] <= PWDATA;
        end
        wl_n <= wl_n + 1;
      end else if (PADDR == 5'h04) begin
        rd_cnt <= rd_cnt + 1;
        if (rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 8'd1;
      end
      if (slverr_req != slverr_done) slverr_done <= slverr_done + 1;
    end
  end

  // Protocol monitor: stable address/data through a transfer, idle gap after it
  int         proto_bad = 0;
  logic       prev_done = 1'b0;
  logic [4:0] s_addr = 5'h00;
  logic [7:0] s_data = 8'h00;
  logic       s_write = 1'b0;
  always @(negedge PCLK) begin
    if (PSEL && !PENABLE) begin
      if (prev_done) proto_bad++;
      s_addr  = PADDR;
      s_data  = PWDATA;
      s_write = PWRITE;
    end
    if (PSEL && PENABLE && (PADDR != s_addr || PWDATA != s_data || PWRITE != s_write))
      proto_bad++;
    prev_done = PSEL && PENABLE && PREADY;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_rx(input logic [7:0] b);
    rxmem[wr_ptr[3:0]] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic recv(input string tag, input logic [7:0] ed, input logic [2:0] ee);
    int n = 0;
    while (!rx_valid && n < 300) begin
      @(negedge PCLK);
      n++;
    end
    check({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, rx_data}, {24'd0, ed});
    check({tag, "_err"}, {29'd0, rx_err}, {29'd0, ee});
    @(negedge PCLK);
  endtask

  initial begin
    int rd0, wl0, n;
    PRESETN  = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    rx_ready = 1'b1;
    repeat (3) @(negedge PCLK);

    check("rst_psel", {31'd0, PSEL}, 32'd0);
    check("rst_penable", {31'd0, PENABLE}, 32'd0);
    check("rst_pwrite", {31'd0, PWRITE}, 32'd0);
    check("rst_paddr", {27'd0, PADDR}, 32'd0);
    check("rst_pwdata", {24'd0, PWDATA}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_err", {29'd0, rx_err}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_apb_err", {31'd0, apb_err}, 32'd0);

    PRESETN = 1'b1;
    n = 0;
    while (!init_done && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    check("init_done", {31'd0, init_done}, 32'd1);
    check("cfg_write_count", wl_n, 32'd2);
    check("cfg1_addr", {27'd0, wl_addr[0]}, 32'h08);
    check("cfg1_data", {24'd0, wl_data[0]}, 32'h45);
    check("cfg2_addr", {27'd0, wl_addr[1]}, 32'h0C);
    check("cfg2_data", {24'd0, wl_data[1]}, 32'h29);
    check("tx_ready_after_init", {31'd0, tx_ready}, 32'd1);

    // TX with three wait states in ACCESS
    wait_n   = 3;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge PCLK);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    check("tx_ready_drop", {31'd0, tx_ready}, 32'd0);
    n = 0;
    while (wl_n < 3 && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    check("tx_write_count", wl_n, 32'd3);
    check("tx_addr", {27'd0, wl_addr[2]}, 32'h00);
    check("tx_data", {24'd0, wl_data[2]}, 32'hA5);
    check("tx_ready_return", {31'd0, tx_ready}, 32'd1);
    wait_n = 0;

    // Two received bytes with the consumer ready
    push_rx(8'h3C);
    push_rx(8'hC3);
    recv("rx0", 8'h3C, 3'b000);
    recv("rx1", 8'hC3, 3'b000);

    // Backpressure: only one read of RXDATA while rx_ready is low
    rx_ready = 1'b0;
    rd0 = rd_cnt;
    push_rx(8'h11);
    push_rx(8'h22);
    push_rx(8'h33);
    push_rx(8'h44);
    repeat (100) @(negedge PCLK);
    check("bp_single_read", rd_cnt, rd0 + 1);
    check("bp_valid_held", {31'd0, rx_valid}, 32'd1);
    check("bp_first_byte", {24'd0, rx_data}, 32'h11);
    rx_ready = 1'b1;
    @(negedge PCLK);
    recv("bp1", 8'h22, 3'b000);
    recv("bp2", 8'h33, 3'b000);
    recv("bp3", 8'h44, 3'b000);
    check("bp_total_reads", rd_cnt, rd0 + 4);

    // Parity error attached to the byte that follows the status read
    st_err = 3'b001;
    push_rx(8'h5A);
    recv("par", 8'h5A, 3'b001);
    st_err = 3'b000;
    check("apb_err_clear", {31'd0, apb_err}, 32'd0);

    slverr_req = slverr_req + 1;
    n = 0;
    while (!apb_err && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    check("apb_err_set", {31'd0, apb_err}, 32'd1);
    repeat (20) @(negedge PCLK);
    check("apb_err_sticky", {31'd0, apb_err}, 32'd1);

    // Reset in the middle of an extended ACCESS phase
    wait_n = 5;
    n = 0;
    while (!(PSEL && PENABLE) && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    check("access_seen", {31'd0, PSEL && PENABLE}, 32'd1);
    #2 PRESETN = 1'b0;
    #1;
    check("mid_rst_psel", {31'd0, PSEL}, 32'd0);
    check("mid_rst_penable", {31'd0, PENABLE}, 32'd0);
    check("mid_rst_apb_err", {31'd0, apb_err}, 32'd0);
    check("mid_rst_init_done", {31'd0, init_done}, 32'd0);
    wait_n = 0;
    @(negedge PCLK);
    wl0 = wl_n;
    PRESETN = 1'b1;
    n = 0;
    while (wl_n == wl0 && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    check("restart_addr", {27'd0, wl_addr[wl0]}, 32'h08);
    check("restart_data", {24'd0, wl_data[wl0]}, 32'h45);
    repeat (10) @(negedge PCLK);
    check("apb_protocol", proto_bad, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
